// File: rtl/bus_pkg.sv
// Shared constants and types for the internal-bus arbiter.
// Requester indices double as the word-mux select codes.
package bus_pkg;
   localparam int REQ_N  = 4;
   localparam int SEL_W  = 2;
   localparam int WORD_W = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [SEL_W-1:0] REQ_ALU = 2'd0;
   localparam logic [SEL_W-1:0] REQ_MEM = 2'd1;
   localparam logic [SEL_W-1:0] REQ_IMM = 2'd2;
   localparam logic [SEL_W-1:0] REQ_RF  = 2'd3;

   typedef struct packed {
      logic             found;
      logic [SEL_W-1:0] idx;
   } pick_t;
endpackage

// File: rtl/wordmux4.sv
// 4-way bus word mux with an output enable; zero when not enabled.
module wordmux4
   import bus_pkg::*;
(
   input  logic [0:SEL_W-1]  sel,
   input  logic              en,
   input  logic [0:WORD_W-1] d0,
   input  logic [0:WORD_W-1] d1,
   input  logic [0:WORD_W-1] d2,
   input  logic [0:WORD_W-1] d3,
   output logic [0:WORD_W-1] q
);
   logic [0:WORD_W-1] mux;

   always_comb begin
      mux = '0;
      case (sel)
         REQ_ALU: mux = d0;
         REQ_MEM: mux = d1;
         REQ_IMM: mux = d2;
         REQ_RF:  mux = d3;
         default: mux = '0;
      endcase
   end

   assign q = en ? mux : '0;
endmodule

// File: rtl/bus_arbiter4.sv
// Round-robin owner of the 16-bit internal bus with hold-limit preemption.
// Grant/select are registered; only the data path is combinational.
module bus_arbiter4
   import bus_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   parameter int HOLD_W   = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [0:REQ_N-1]  i_req,
   input  logic [0:WORD_W-1] i_data0,
   input  logic [0:WORD_W-1] i_data1,
   input  logic [0:WORD_W-1] i_data2,
   input  logic [0:WORD_W-1] i_data3,
   output logic [0:REQ_N-1]  o_gnt,
   output logic [0:SEL_W-1]  o_sel,
   output logic              o_valid,
   output logic [0:WORD_W-1] o_data
);
   state_t             state_q, state_n;
   logic [SEL_W-1:0]   ptr_q, ptr_n;
   logic [SEL_W-1:0]   sel_q, sel_n;
   logic [HOLD_W-1:0]  cnt_q, cnt_n;
   logic [0:REQ_N-1]   gnt_q, gnt_n;
   logic [SEL_W-1:0]   nxt_ptr;
   logic [0:REQ_N-1]   others;
   pick_t              pk;

   // First set bit of req scanning start, start+1, ... modulo REQ_N.
   function automatic pick_t rr_pick(input logic [0:REQ_N-1] req,
                                     input logic [SEL_W-1:0] start);
      pick_t            p;
      logic [SEL_W-1:0] idx;
      p = '0;
      for (int i = REQ_N-1; i >= 0; i--) begin
         idx = start + SEL_W'(i);
         if (req[idx]) begin
            p.found = 1'b1;
            p.idx   = idx;
         end
      end
      return p;
   endfunction

   function automatic logic [0:REQ_N-1] onehot(input logic [SEL_W-1:0] i);
      logic [0:REQ_N-1] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   assign nxt_ptr = sel_q + SEL_W'(1);
   assign others  = i_req & ~onehot(sel_q);

   always_comb begin
      state_n = state_q;
      ptr_n   = ptr_q;
      sel_n   = sel_q;
      cnt_n   = cnt_q;
      gnt_n   = gnt_q;
      pk      = '0;
      case (state_q)
         IDLE: begin
            pk = rr_pick(i_req, ptr_q);
            if (pk.found) begin
               state_n = GRANT;
               sel_n   = pk.idx;
               gnt_n   = onehot(pk.idx);
               cnt_n   = '0;
            end
         end
         GRANT: begin
            if (!i_req[sel_q]) begin
               // Release wins over a coincident timeout.
               ptr_n = nxt_ptr;
               pk    = rr_pick(others, nxt_ptr);
               cnt_n = '0;
               if (pk.found) begin
                  sel_n = pk.idx;
                  gnt_n = onehot(pk.idx);
               end else begin
                  state_n = IDLE;
                  gnt_n   = '0;
               end
            end else if (cnt_q == HOLD_W'(MAX_HOLD-1)) begin
               cnt_n = '0;
               if (|others) begin
                  ptr_n = nxt_ptr;
                  pk    = rr_pick(others, nxt_ptr);
                  sel_n = pk.idx;
                  gnt_n = onehot(pk.idx);
               end
            end else begin
               cnt_n = cnt_q + HOLD_W'(1);
            end
         end
         default: begin
            state_n = IDLE;
            gnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         sel_q   <= '0;
         cnt_q   <= '0;
         gnt_q   <= '0;
      end else begin
         state_q <= state_n;
         ptr_q   <= ptr_n;
         sel_q   <= sel_n;
         cnt_q   <= cnt_n;
         gnt_q   <= gnt_n;
      end
   end

   assign o_gnt   = gnt_q;
   assign o_sel   = sel_q;
   assign o_valid = (state_q == GRANT);

   wordmux4 u_mux (
      .sel (sel_q),
      .en  (o_valid),
      .d0  (i_data0),
      .d1  (i_data1),
      .d2  (i_data2),
      .d3  (i_data3),
      .q   (o_data)
   );
endmodule

// File: tb/tb_bus_arbiter4.sv
// Scoreboard bench for bus_arbiter4 (MAX_HOLD=4): each cycle pushes the
// hand-derived owner outcome and compares it after the following edge.
module tb_bus_arbiter4;
   typedef struct packed {
      logic [0:3]  gnt;
      logic [0:1]  sel;
      logic        valid;
      logic [0:15] data;
   } obs_t;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic [0:3]  i_req;
   logic [0:15] i_data0, i_data1, i_data2, i_data3;
   logic [0:3]  o_gnt;
   logic [0:1]  o_sel;
   logic        o_valid;
   logic [0:15] o_data;

   obs_t        sb[$];
   logic [0:1]  hold_sel;
   int          passed = 0;
   int          total  = 0;

   bus_arbiter4 #(.MAX_HOLD(4), .HOLD_W(8)) dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_req   (i_req),
      .i_data0 (i_data0),
      .i_data1 (i_data1),
      .i_data2 (i_data2),
      .i_data3 (i_data3),
      .o_gnt   (o_gnt),
      .o_sel   (o_sel),
      .o_valid (o_valid),
      .o_data  (o_data)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [0:15] word_of(input int n);
      case (n)
         0: return 16'hA0A0;
         1: return 16'hBEEF;
         2: return 16'hC2C2;
         default: return 16'hD3D3;
      endcase
   endfunction

   // Drive one cycle of stimulus and push what must appear after the edge.
   // owner < 0 means no grant expected; select then holds its last value.
   task automatic apply(input logic rst, input logic [0:3] req, input int owner);
      obs_t e;
      @(negedge i_clk);
      i_rst = rst;
      i_req = req;
      if (rst) hold_sel = 2'd0;
      if (owner >= 0) hold_sel = 2'(owner);
      e.gnt   = 4'b0000;
      e.valid = (owner >= 0);
      e.sel   = hold_sel;
      e.data  = 16'h0000;
      if (owner >= 0) begin
         e.gnt[owner] = 1'b1;
         e.data       = word_of(owner);
      end
      sb.push_back(e);
      @(posedge i_clk);
      #1;
   endtask

   task automatic test_reset;
      logic [0:3] rq [5] = '{4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0000};
      logic       rs [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      int         ow [5] = '{-1, -1, 0, -1, -1};
      obs_t e, got;
      for (int r = 0; r < 5; r++) begin
         apply(rs[r], rq[r], ow[r]);
         got = {o_gnt, o_sel, o_valid, o_data};
         e   = sb.pop_front();
         total++;
         if (got !== e)
            $display("FAIL reset row %0d: got gnt=%b sel=%b vld=%b data=%h, want gnt=%b sel=%b vld=%b data=%h",
                     r, got.gnt, got.sel, got.valid, got.data, e.gnt, e.sel, e.valid, e.data);
         else passed++;
      end
   endtask

   task automatic test_single;
      logic [0:3] rq [3] = '{4'b0100, 4'b0100, 4'b0000};
      int         ow [3] = '{1, 1, -1};
      obs_t e, got;
      for (int r = 0; r < 3; r++) begin
         apply(1'b0, rq[r], ow[r]);
         got = {o_gnt, o_sel, o_valid, o_data};
         e   = sb.pop_front();
         total++;
         if (got !== e)
            $display("FAIL single row %0d: got gnt=%b sel=%b vld=%b data=%h, want gnt=%b sel=%b vld=%b data=%h",
                     r, got.gnt, got.sel, got.valid, got.data, e.gnt, e.sel, e.valid, e.data);
         else passed++;
      end
   endtask

   // Each owner drops its bit for one cycle: grants rotate with no gaps.
   task automatic test_round_robin;
      logic [0:3] rq [8] = '{4'b0000, 4'b1111, 4'b0111, 4'b1011,
                             4'b1101, 4'b1110, 4'b0111, 4'b0000};
      logic       rs [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      int         ow [8] = '{-1, 0, 1, 2, 3, 0, 1, -1};
      obs_t e, got;
      for (int r = 0; r < 8; r++) begin
         apply(rs[r], rq[r], ow[r]);
         got = {o_gnt, o_sel, o_valid, o_data};
         e   = sb.pop_front();
         total++;
         if (got !== e)
            $display("FAIL round_robin row %0d: got gnt=%b sel=%b vld=%b data=%h, want gnt=%b sel=%b vld=%b data=%h",
                     r, got.gnt, got.sel, got.valid, got.data, e.gnt, e.sel, e.valid, e.data);
         else passed++;
      end
   endtask

   // Owner 2 is cut after 4 cycles when 3 waits; alone it keeps the bus.
   task automatic test_preempt;
      logic [0:3] rq [13] = '{4'b0010, 4'b0011, 4'b0011, 4'b0011, 4'b0011,
                              4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
                              4'b0010, 4'b0010, 4'b0000};
      int         ow [13] = '{2, 2, 2, 2, 3, 2, 2, 2, 2, 2, 2, 2, -1};
      obs_t e, got;
      for (int r = 0; r < 13; r++) begin
         apply(1'b0, rq[r], ow[r]);
         got = {o_gnt, o_sel, o_valid, o_data};
         e   = sb.pop_front();
         total++;
         if (got !== e)
            $display("FAIL preempt row %0d: got gnt=%b sel=%b vld=%b data=%h, want gnt=%b sel=%b vld=%b data=%h",
                     r, got.gnt, got.sel, got.valid, got.data, e.gnt, e.sel, e.valid, e.data);
         else passed++;
      end
   endtask

   // Owner 3 drops exactly when its hold limit expires.
   task automatic test_simultaneous;
      logic [0:3] rq [8] = '{4'b1001, 4'b1001, 4'b1001, 4'b1001,
                             4'b1100, 4'b1100, 4'b0100, 4'b0000};
      int         ow [8] = '{3, 3, 3, 3, 0, 0, 1, -1};
      obs_t e, got;
      for (int r = 0; r < 8; r++) begin
         apply(1'b0, rq[r], ow[r]);
         got = {o_gnt, o_sel, o_valid, o_data};
         e   = sb.pop_front();
         total++;
         if (got !== e)
            $display("FAIL simultaneous row %0d: got gnt=%b sel=%b vld=%b data=%h, want gnt=%b sel=%b vld=%b data=%h",
                     r, got.gnt, got.sel, got.valid, got.data, e.gnt, e.sel, e.valid, e.data);
         else passed++;
      end
   endtask

   // Pointer sits at 2 before reset; afterwards 1001 must go to requester 0.
   task automatic test_reset_mid;
      logic [0:3] rq [4] = '{4'b1000, 4'b1000, 4'b1001, 4'b0000};
      logic       rs [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      int         ow [4] = '{0, -1, 0, -1};
      obs_t e, got;
      for (int r = 0; r < 4; r++) begin
         apply(rs[r], rq[r], ow[r]);
         got = {o_gnt, o_sel, o_valid, o_data};
         e   = sb.pop_front();
         total++;
         if (got !== e)
            $display("FAIL reset_mid row %0d: got gnt=%b sel=%b vld=%b data=%h, want gnt=%b sel=%b vld=%b data=%h",
                     r, got.gnt, got.sel, got.valid, got.data, e.gnt, e.sel, e.valid, e.data);
         else passed++;
      end
   endtask

   initial begin
      i_rst    = 1'b1;
      i_req    = 4'b0000;
      i_data0  = word_of(0);
      i_data1  = word_of(1);
      i_data2  = word_of(2);
      i_data3  = word_of(3);
      hold_sel = 2'd0;
      test_reset();
      test_single();
      test_round_robin();
      test_preempt();
      test_simultaneous();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
